// File: rtl/ahblite_slave_mux_n.sv
// ---------------------------------------------------------------------------
// ahblite_slave_mux_n
//
// AHB-Lite slave-side interconnect for one master and NPORT slaves plus an
// internal default slave. The address phase is decoded combinationally from
// HADDR[31:28]; the data-phase select is registered when HREADY is high and
// steers the slave responses back to the master. Unmapped NONSEQ/SEQ
// transfers are answered by the default slave with a two-cycle ERROR
// response, which is also logged (address, saturating count, pulse).
//
// Ports
//   clk          in   clock, rising edge
//   RSTn         in   asynchronous active-low reset
//   HADDR        in   [31:0]        master address
//   HTRANS       in   [1:0]         master transfer type
//   HWRITE       in                 master write flag (routed to slaves externally)
//   HRDATA       out  [31:0]        read data to master
//   HREADY       out                ready to master, also broadcast to slaves
//   HRESP        out                response to master
//   HSEL_P       out  [NPORT-1:0]   per-port address-phase select
//   HREADYOUT_P  in   [NPORT-1:0]   per-port ready
//   HRDATA_P     in   [32*NPORT-1:0] per-port read data, port i at [32i+31:32i]
//   HRESP_P      in   [NPORT-1:0]   per-port response
//   err_clr      in                 synchronous clear of error status
//   err_irq      out                high for the second cycle of each ERROR
//   err_addr     out  [31:0]        address of the latest decode error
//   err_cnt      out  [ERR_CNT_W-1:0] saturating decode-error count
// ---------------------------------------------------------------------------
module ahblite_slave_mux_n #(
    parameter int unsigned        NPORT     = 4,
    parameter logic [4*NPORT-1:0] PORT_MAP  = {4'h5, 4'h4, 4'h2, 4'h0},
    parameter int unsigned        ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   RSTn,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    output logic [31:0]            HRDATA,
    output logic                   HREADY,
    output logic                   HRESP,
    output logic [NPORT-1:0]       HSEL_P,
    input  logic [NPORT-1:0]       HREADYOUT_P,
    input  logic [32*NPORT-1:0]    HRDATA_P,
    input  logic [NPORT-1:0]       HRESP_P,
    input  logic                   err_clr,
    output logic                   err_irq,
    output logic [31:0]            err_addr,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_e;

    // Bit NPORT of the select vectors is the default slave.
    logic [NPORT:0]          addr_sel;
    logic                    addr_hit;
    logic [NPORT:0]          dsel_q, dsel_d;
    dflt_state_e             state_q, state_d;
    logic [31:0]             err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                    dflt_ready, dflt_resp;
    logic                    err_start;
    logic                    mux_ready, mux_resp;
    logic [31:0]             mux_rdata;

    // HWRITE and the SEQ/NONSEQ distinction do not affect routing.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, HWRITE, HTRANS[0]};

    // ------------------------------------------------------------------
    // Address-phase decode: one-hot, lowest matching port wins.
    // ------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default at the
    // top so no path leaves it unassigned, which would infer a latch.
    always_comb begin : addr_decode
        addr_sel = '0;
        addr_hit = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (!addr_hit && (HADDR[31:28] == PORT_MAP[4*i +: 4])) begin
                addr_sel[i] = 1'b1;
                addr_hit    = 1'b1;
            end
        end
        addr_sel[NPORT] = !addr_hit;
    end

    assign HSEL_P = addr_sel[NPORT-1:0];

    // ------------------------------------------------------------------
    // Data-phase response mux. An empty select (only after reset) answers
    // as an always-ready OKAY slave.
    // ------------------------------------------------------------------
    always_comb begin : data_mux
        mux_ready = 1'b1;
        mux_resp  = 1'b0;
        mux_rdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (dsel_q[i]) begin
                mux_ready = HREADYOUT_P[i];
                mux_resp  = HRESP_P[i];
                mux_rdata = HRDATA_P[32*i +: 32];
            end
        end
        if (dsel_q[NPORT]) begin
            mux_ready = dflt_ready;
            mux_resp  = dflt_resp;
        end
    end

    assign HREADY = mux_ready;
    assign HRESP  = mux_resp;
    assign HRDATA = mux_rdata;

    // The select only advances when the current data phase completes.
    assign dsel_d = HREADY ? addr_sel : dsel_q;

    // ------------------------------------------------------------------
    // Default slave FSM: next state
    // ------------------------------------------------------------------
    // HREADY is low throughout ERR1, so a new error can only start from
    // IDLE or ERR2.
    assign err_start = addr_sel[NPORT] && HTRANS[1] && HREADY;

    always_comb begin : dflt_next
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (err_start) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_start ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Default slave FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin : dflt_out
        dflt_ready = 1'b1;
        dflt_resp  = 1'b0;
        err_irq    = 1'b0;
        case (state_q)
            ST_ERR1: begin
                dflt_ready = 1'b0;
                dflt_resp  = 1'b1;
            end
            ST_ERR2: begin
                dflt_resp = 1'b1;
                err_irq   = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Error log. Clear has priority over both capture and count.
    // ------------------------------------------------------------------
    always_comb begin : err_log
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (err_clr) begin
            err_addr_d = '0;
            err_cnt_d  = '0;
        end else begin
            if (state_d == ST_ERR1) err_addr_d = HADDR;
            if ((state_q == ST_ERR2) && (err_cnt_q != {ERR_CNT_W{1'b1}}))
                err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            dsel_q     <= '0;
            state_q    <= ST_IDLE;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            dsel_q     <= dsel_d;
            state_q    <= state_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_ahblite_slave_mux_n.sv
// ---------------------------------------------------------------------------
// tb_ahblite_slave_mux_n
//
// Drives two instances of ahblite_slave_mux_n from the same stimulus:
//   u_dut0 - default parameters (map 5/4/2/0, 8-bit error counter)
//   u_dut1 - map 5/2/2/0 (duplicate entry) with a 2-bit error counter
// A transaction-level reference model tracks, per instance, which target
// owns the data phase and where an ERROR response is in its two cycles.
// Directed scenarios come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_ahblite_slave_mux_n;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic         clk = 1'b0;
    logic         RSTn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [3:0]   hro;
    logic [127:0] hrd;
    logic [3:0]   hrsp;
    logic         err_clr;

    logic [31:0]  hrdata_o [2];
    logic         hready_o [2];
    logic         hresp_o  [2];
    logic [3:0]   hsel_o   [2];
    logic         irq_o    [2];
    logic [31:0]  eaddr_o  [2];
    logic [7:0]   cnt0;
    logic [1:0]   cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, one entry per instance.
    // m_dp: -1 no data phase, 0..3 real port, 4 default slave.
    // m_stg: 0 no error, 1 first ERROR cycle, 2 second ERROR cycle.
    int          m_dp   [2];
    int          m_stg  [2];
    int          m_cnt  [2];
    int          m_max  [2];
    logic [31:0] m_addr [2];
    logic [15:0] m_map  [2];
    logic        m_rdy  [2];

    always #5 clk = ~clk;

    ahblite_slave_mux_n u_dut0 (
        .clk(clk), .RSTn(RSTn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HRDATA(hrdata_o[0]), .HREADY(hready_o[0]), .HRESP(hresp_o[0]),
        .HSEL_P(hsel_o[0]), .HREADYOUT_P(hro), .HRDATA_P(hrd), .HRESP_P(hrsp),
        .err_clr(err_clr), .err_irq(irq_o[0]), .err_addr(eaddr_o[0]), .err_cnt(cnt0)
    );

    ahblite_slave_mux_n #(
        .NPORT(4), .PORT_MAP(16'h5220), .ERR_CNT_W(2)
    ) u_dut1 (
        .clk(clk), .RSTn(RSTn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HRDATA(hrdata_o[1]), .HREADY(hready_o[1]), .HRESP(hresp_o[1]),
        .HSEL_P(hsel_o[1]), .HREADYOUT_P(hro), .HRDATA_P(hrd), .HRESP_P(hrsp),
        .err_clr(err_clr), .err_irq(irq_o[1]), .err_addr(eaddr_o[1]), .err_cnt(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int decode(input int k, input logic [31:0] a);
        logic [15:0] mp;
        mp = m_map[k];
        for (int i = 0; i < 4; i++)
            if (mp[4*i +: 4] == a[31:28]) return i;
        return 4;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_dp[k]   = -1;
            m_stg[k]  = 0;
            m_cnt[k]  = 0;
            m_addr[k] = '0;
            m_rdy[k]  = 1'b1;
        end
    endtask

    // Compare every DUT output against what the model predicts right now.
    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            logic        er, ep;
            logic [31:0] ed;
            logic [3:0]  eh;
            logic [31:0] got_cnt;
            int          d;
            er = 1'b1; ep = 1'b0; ed = '0;
            if (m_dp[k] >= 0 && m_dp[k] < 4) begin
                er = hro[m_dp[k]];
                ep = hrsp[m_dp[k]];
                ed = hrd[32*m_dp[k] +: 32];
            end else if (m_dp[k] == 4) begin
                er = (m_stg[k] != 1);
                ep = (m_stg[k] != 0);
            end
            m_rdy[k] = er;
            d  = decode(k, HADDR);
            eh = (d < 4) ? 4'(1 << d) : 4'b0000;
            got_cnt = (k == 0) ? 32'(cnt0) : 32'(cnt1);
            check($sformatf("dut%0d hready", k), 32'(hready_o[k]), 32'(er));
            check($sformatf("dut%0d hresp", k),  32'(hresp_o[k]),  32'(ep));
            check($sformatf("dut%0d hrdata", k), hrdata_o[k], ed);
            check($sformatf("dut%0d hsel", k),   32'(hsel_o[k]),   32'(eh));
            check($sformatf("dut%0d err_irq", k), 32'(irq_o[k]), 32'(m_stg[k] == 2));
            check($sformatf("dut%0d err_addr", k), eaddr_o[k], m_addr[k]);
            check($sformatf("dut%0d err_cnt", k), got_cnt, 32'(m_cnt[k]));
        end
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_update(input logic [31:0] a, input logic [1:0] t, input logic clr);
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_cnt[k]  = 0;
                m_addr[k] = '0;
            end else if (m_stg[k] == 2 && m_cnt[k] < m_max[k]) begin
                m_cnt[k]++;
            end
            if (m_rdy[k]) begin
                int d;
                d = decode(k, a);
                m_dp[k] = d;
                if (d == 4 && t[1]) begin
                    m_stg[k] = 1;
                    if (!clr) m_addr[k] = a;
                end else begin
                    m_stg[k] = 0;
                end
            end else if (m_stg[k] == 1) begin
                m_stg[k] = 2;
            end
        end
    endtask

    // One bus cycle: drive at the falling edge, check, then update the model.
    // Returns before the next rising edge so callers can add directed checks.
    task automatic cycle(input logic [31:0] a, input logic [1:0] t, input logic w,
                         input logic [3:0] rdy, input logic [3:0] rsp,
                         input logic [127:0] d, input logic clr);
        @(negedge clk);
        HADDR = a; HTRANS = t; HWRITE = w;
        hro = rdy; hrsp = rsp; hrd = d; err_clr = clr;
        #1;
        model_check();
        model_update(a, t, clr);
    endtask

    initial begin
        logic [3:0]   nib_tbl [4];
        logic [127:0] dat;
        nib_tbl = '{4'h0, 4'h2, 4'h4, 4'h5};
        m_map   = '{16'h5420, 16'h5220};
        m_max   = '{255, 3};

        // Reset state
        RSTn = 1'b0;
        HADDR = '0; HTRANS = T_IDLE; HWRITE = 1'b0;
        hro = 4'hF; hrsp = 4'h0; hrd = rand128(); err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("reset hready", 32'(hready_o[0]), 32'd1);
        check("reset hresp",  32'(hresp_o[0]),  32'd0);
        check("reset hrdata", hrdata_o[0], 32'd0);
        check("reset err_irq", 32'(irq_o[0]), 32'd0);
        check("reset err_cnt", 32'(cnt0), 32'd0);
        check("reset err_addr", eaddr_o[0], 32'd0);
        model_check();
        RSTn = 1'b1;

        // Single read from port1; duplicate map entry in dut1 also picks port1
        dat = rand128();
        dat[63:32] = 32'hDEADBEEF;
        cycle(32'h2000_0010, T_NONSEQ, 1'b0, 4'hF, 4'h0, dat, 1'b0);
        check("rd p1 hsel", 32'(hsel_o[0]), 32'h2);
        check("dup map hsel", 32'(hsel_o[1]), 32'h2);
        cycle(32'h0000_0000, T_IDLE, 1'b0, 4'hF, 4'h0, dat, 1'b0);
        check("rd p1 hrdata", hrdata_o[0], 32'hDEADBEEF);
        check("rd p1 hready", 32'(hready_o[0]), 32'd1);
        check("rd p1 hresp",  32'(hresp_o[0]),  32'd0);

        // Write to port2 with three wait states, port0 transfer held behind it
        cycle(32'h4000_0000, T_NONSEQ, 1'b1, 4'hF, 4'h0, rand128(), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(32'h0000_0040, T_NONSEQ, 1'b0, 4'b1011, 4'h0, rand128(), 1'b0);
            check("p2 wait hready", 32'(hready_o[0]), 32'd0);
        end
        cycle(32'h0000_0040, T_NONSEQ, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("p2 done hready", 32'(hready_o[0]), 32'd1);
        dat = rand128();
        dat[31:0] = 32'hCAFE_0123;
        cycle(32'h0000_0000, T_IDLE, 1'b0, 4'hF, 4'h0, dat, 1'b0);
        check("p0 after wait hrdata", hrdata_o[0], 32'hCAFE_0123);

        // Single decode error
        cycle(32'h9000_0004, T_NONSEQ, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("unmapped hsel", 32'(hsel_o[0]), 32'h0);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("err1 hready", 32'(hready_o[0]), 32'd0);
        check("err1 hresp",  32'(hresp_o[0]),  32'd1);
        check("err1 irq",    32'(irq_o[0]),    32'd0);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("err2 hready", 32'(hready_o[0]), 32'd1);
        check("err2 hresp",  32'(hresp_o[0]),  32'd1);
        check("err2 irq",    32'(irq_o[0]),    32'd1);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("post err irq",  32'(irq_o[0]), 32'd0);
        check("post err addr", eaddr_o[0], 32'h9000_0004);
        check("post err cnt",  32'(cnt0), 32'd1);

        // Back-to-back decode errors
        cycle(32'hA000_0000, T_NONSEQ, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        cycle(32'hB000_0008, T_SEQ, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("b2b err1a", {31'd0, hready_o[0]}, 32'd0);
        cycle(32'hB000_0008, T_SEQ, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("b2b err2a resp", 32'(hresp_o[0]), 32'd1);
        check("b2b err2a rdy",  32'(hready_o[0]), 32'd1);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("b2b err1b", 32'(hready_o[0]), 32'd0);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("b2b err2b", 32'(hresp_o[0]), 32'd1);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("b2b cnt",  32'(cnt0), 32'd3);
        check("b2b addr", eaddr_o[0], 32'hB000_0008);

        // Saturation of the 2-bit counter, clear coinciding with ERR2
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b1);
        for (int e = 1; e <= 5; e++) begin
            cycle(32'h9000_0100 + 32'(e), T_NONSEQ, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
            if (e == 4) check("sat cnt1 at 3 errs", 32'(cnt1), 32'd3);
            if (e == 5) check("sat cnt1 at 4 errs", 32'(cnt1), 32'd3);
            if (e == 5) check("cnt0 at 4 errs", 32'(cnt0), 32'd4);
            cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
            cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), e == 5);
        end
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("clr wins cnt1", 32'(cnt1), 32'd0);
        check("clr wins cnt0", 32'(cnt0), 32'd0);
        check("clr addr", eaddr_o[0], 32'd0);

        // Reset during ERR1
        cycle(32'h9000_0000, T_NONSEQ, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, rand128(), 1'b0);
        check("pre-rst err1", 32'(hready_o[0]), 32'd0);
        RSTn = 1'b0;
        #1;
        model_reset();
        check("rst err1 hready", 32'(hready_o[0]), 32'd1);
        check("rst err1 hresp",  32'(hresp_o[0]),  32'd0);
        check("rst err1 cnt",    32'(cnt0), 32'd0);
        check("rst err1 irq",    32'(irq_o[0]), 32'd0);
        model_check();
        @(posedge clk);
        #2;
        RSTn = 1'b1;
        dat = rand128();
        dat[31:0] = 32'h1234_5678;
        cycle(32'h0000_0100, T_NONSEQ, 1'b0, 4'hF, 4'h0, dat, 1'b0);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, dat, 1'b0);
        check("post-rst rd hready", 32'(hready_o[0]), 32'd1);
        check("post-rst rd hresp",  32'(hresp_o[0]),  32'd0);
        check("post-rst rd hrdata", hrdata_o[0], 32'h1234_5678);
        cycle(32'h0, T_IDLE, 1'b0, 4'hF, 4'h0, dat, 1'b0);
        check("post-rst irq", 32'(irq_o[0]), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            logic [3:0]  rdy, rsp;
            int          r;
            a = $urandom;
            r = $urandom_range(0, 9);
            if (r < 8) a[31:28] = nib_tbl[r % 4];
            for (int b = 0; b < 4; b++) begin
                rdy[b] = ($urandom_range(0, 4) != 0);
                rsp[b] = ($urandom_range(0, 9) == 0);
            end
            cycle(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rdy, rsp,
                  rand128(), ($urandom_range(0, 24) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahblite_slave_mux_n.md
AHBLITE_SLAVE_MUX_N -- requirements
Module: ahblite_slave_mux_n

Interface
REQ-001 Parameter NPORT, default 4: number of slave ports, legal range 1..8.
REQ-002 Parameter PORT_MAP, width 4*NPORT, default {4'h5,4'h4,4'h2,4'h0}: nibble i is the HADDR[31:28] value that selects port i.
REQ-003 Parameter ERR_CNT_W, default 8: width of the error counter.
REQ-004 clk  input  1: clock; all state updates on the rising edge.
REQ-005 RSTn  input  1: reset, asynchronous, active-low.
REQ-006 HADDR  input  32: master address.
REQ-007 HTRANS  input  2: master transfer type.
REQ-008 HWRITE  input  1: master write flag.
REQ-009 HRDATA  output  32: read data returned to the master.
REQ-010 HREADY  output  1: ready to the master; also broadcast to all slaves.
REQ-011 HRESP  output  1: response to the master.
REQ-012 HSEL_P  output  NPORT: per-port address-phase select.
REQ-013 HREADYOUT_P  input  NPORT: per-port ready.
REQ-014 HRDATA_P  input  32*NPORT: per-port read data, port i in bits [32i+31:32i].
REQ-015 HRESP_P  input  NPORT: per-port response.
REQ-016 err_clr  input  1: synchronous clear of the error status.
REQ-017 err_irq  output  1: one-cycle pulse when a decode error completes.
REQ-018 err_addr  output  32: HADDR of the most recent decode-error transfer.
REQ-019 err_cnt  output  ERR_CNT_W: number of decode errors, saturating.

Function
REQ-020 HSEL_P[i] SHALL be combinational and equal 1 iff HADDR[31:28]==PORT_MAP[4i+3:4i]; the lowest matching index wins if entries duplicate.
REQ-021 When no port matches, the default slave SHALL be selected internally.
REQ-022 The data-phase select register (NPORT+1 one-hot, including the default slave) SHALL load the address-phase select only when HREADY=1.
REQ-023 HRDATA, HREADY and HRESP SHALL be muxed from the data-phase selected port.
REQ-024 With no data-phase selection (after reset), outputs SHALL be HREADY=1, HRESP=0, HRDATA=0.
REQ-025 The default slave SHALL run a 3-state FSM: IDLE, ERR1, ERR2.
  - IDLE -> ERR1: default slave selected, HTRANS[1]=1, HREADY=1.
  - ERR1: drives HREADY=0, HRESP=1; always goes to ERR2.
  - ERR2: drives HREADY=1, HRESP=1; goes to ERR1 if a new unmapped NONSEQ/SEQ is presented, else to IDLE.
REQ-026 Default-slave IDLE/BUSY transfers SHALL complete with zero wait states: HREADY=1, HRESP=0.
REQ-027 Default-slave HRDATA SHALL be 0.
REQ-028 err_addr SHALL capture HADDR on the IDLE/ERR2 -> ERR1 transition.
REQ-029 err_irq SHALL pulse high for exactly the ERR2 cycle.
REQ-030 err_cnt SHALL increment by 1 in ERR2 and saturate at 2^ERR_CNT_W-1.
REQ-031 err_clr=1 SHALL zero err_cnt and err_addr on the next edge; if it coincides with ERR2, clear wins and err_cnt reads 0.
REQ-032 Wait states from a real slave (HREADYOUT_P=0) SHALL be passed through unchanged and hold the data-phase register.
REQ-033 The module SHALL add no latency: the address phase is combinational and the data-phase mux is one register stage.

Reset
REQ-034 RSTn low SHALL asynchronously force:
  - data-phase select to none;
  - FSM to IDLE;
  - err_cnt=0, err_addr=0, err_irq=0;
  - outputs to HREADY=1, HRESP=0, HRDATA=0.
REQ-035 RSTn asserted mid-ERR1 SHALL abandon the error response, leave err_cnt unchanged from 0, and resume normally after release.

Verification
REQ-036 Read of 0x2000_0010 (port1), HRDATA_P port1=0xDEADBEEF, HREADYOUT_P=1 -> HSEL_P=4'b0010 in the address phase; next cycle HRDATA=0xDEADBEEF, HREADY=1, HRESP=0.
REQ-037 Write to 0x4000_0000 with port2 HREADYOUT low for 3 cycles -> HREADY low for 3 cycles; the data-phase select is held; a back-to-back transfer to port0 is not issued until HREADY=1.
REQ-038 NONSEQ read to 0x9000_0004 (unmapped) -> HSEL_P=0; then ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1); err_irq pulses once; err_addr=0x9000_0004; err_cnt=1.
REQ-039 Two back-to-back unmapped NONSEQs -> sequence ERR1, ERR2, ERR1, ERR2; err_cnt=2; err_addr holds the second address.
REQ-040 With ERR_CNT_W=2, five decode errors -> err_cnt saturates at 3; err_clr asserted during the fifth ERR2 -> err_cnt=0.
REQ-041 RSTn pulsed low during ERR1 -> HREADY=1, HRESP=0 immediately; FSM in IDLE; err_cnt=0; a subsequent port0 read completes as OKAY.
